sram_arbiter: RTL and testbench

//  Sits directly downstream of the cpu core. Merges the IF fetch port and the MEM data port

---
 rtl/sram_arbiter.sv | 170 +++++++++++++++++
 tb/tb_sram_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// Shares one asynchronous 16-bit SRAM between the core's fetch port and its data port.
// Define UART_MMIO_EN to decode 0xBF00/0xBF01 as UART registers instead of SRAM.
module sram_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst_addr_i,
  input  logic        inst_en_i,
  output logic [15:0] inst_data_o,
  input  logic [15:0] mem_addr_i,
  input  logic [15:0] mem_wdata_i,
  input  logic        mem_re_i,
  input  logic        mem_we_i,
  output logic [15:0] mem_rdata_o,
  output logic        stall_o,
  output logic [17:0] ram_addr_o,
  input  logic [15:0] ram_dq_i,
  output logic [15:0] ram_dq_o,
  output logic        ram_dq_oe_o,
  output logic        ram_ce_n_o,
  output logic        ram_oe_n_o,
  output logic        ram_we_n_o,
  output logic [7:0]  uart_tx_data_o,
  output logic        uart_tx_valid_o,
  input  logic        uart_tx_ready_i,
  input  logic [7:0]  uart_rx_data_i,
  input  logic        uart_rx_valid_i,
  output logic        uart_rx_ack_o
);

  localparam int CW = $clog2(WAIT_CYCLES + 2);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_DRD  = 3'd1;
  localparam logic [2:0] S_DWR  = 3'd2;
  localparam logic [2:0] S_IRD  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
`ifdef UART_MMIO_EN
  localparam logic [2:0]  S_UART    = 3'd5;
  localparam logic [14:0] MMIO_PAGE = 15'h5F80;
`endif
  localparam logic [CW-1:0] RD_LAST = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] WR_LAST = CW'(WAIT_CYCLES + 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   iaddr_q, iaddr_d, maddr_q, maddr_d, wdata_q, wdata_d;
  logic [15:0]   inst_q, inst_d, rdata_q, rdata_d;
  logic          ireq_q, ireq_d, rreq_q, rreq_d, wreq_q, wreq_d;
  logic [7:0]    txd_q, txd_d;
  logic [15:0]   bus_addr;

  // Requests are only sampled in IDLE; later phases work from the latched copies.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    iaddr_d = iaddr_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    ireq_d  = ireq_q;
    rreq_d  = rreq_q;
    wreq_d  = wreq_q;
    inst_d  = inst_q;
    rdata_d = rdata_q;
    txd_d   = txd_q;
    case (state_q)
      S_IDLE: begin
        cnt_d   = '0;
        iaddr_d = inst_addr_i;
        maddr_d = mem_addr_i;
        wdata_d = mem_wdata_i;
        ireq_d  = inst_en_i;
        rreq_d  = mem_re_i;
        wreq_d  = mem_we_i;
        if (mem_we_i)       state_d = S_DWR;
        else if (mem_re_i)  state_d = S_DRD;
        else if (inst_en_i) state_d = S_IRD;
`ifdef UART_MMIO_EN
        if ((mem_we_i || mem_re_i) && mem_addr_i[15:1] == MMIO_PAGE) state_d = S_UART;
        if (mem_we_i && mem_addr_i == 16'hBF00) txd_d = mem_wdata_i[7:0];
`endif
      end
      S_DRD: if (cnt_q == RD_LAST) begin
        rdata_d = ram_dq_i;
        cnt_d   = '0;
        state_d = ireq_q ? S_IRD : S_DONE;
      end
      S_DWR: if (cnt_q == WR_LAST) begin
        cnt_d   = '0;
        state_d = ireq_q ? S_IRD : S_DONE;
      end
      S_IRD: if (cnt_q == RD_LAST) begin
        inst_d  = ram_dq_i;
        cnt_d   = '0;
        state_d = S_DONE;
      end
`ifdef UART_MMIO_EN
      S_UART: begin
        cnt_d = '0;
        if (!wreq_q && rreq_q)
          rdata_d = maddr_q[0] ? {14'b0, uart_rx_valid_i, uart_tx_ready_i} : {8'h00, uart_rx_data_i};
        state_d = ireq_q ? S_IRD : S_DONE;
      end
`endif
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      iaddr_q <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      ireq_q  <= 1'b0;
      rreq_q  <= 1'b0;
      wreq_q  <= 1'b0;
      inst_q  <= '0;
      rdata_q <= '0;
      txd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      iaddr_q <= iaddr_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      ireq_q  <= ireq_d;
      rreq_q  <= rreq_d;
      wreq_q  <= wreq_d;
      inst_q  <= inst_d;
      rdata_q <= rdata_d;
      txd_q   <= txd_d;
    end
  end

  // Strobes decode straight from state so a reset edge releases them immediately.
  assign bus_addr    = (state_q == S_IRD) ? iaddr_q :
                       (state_q == S_DRD || state_q == S_DWR) ? maddr_q : 16'h0000;
  assign ram_addr_o  = {2'b00, bus_addr};
  assign ram_ce_n_o  = !(state_q == S_DRD || state_q == S_DWR || state_q == S_IRD);
  assign ram_oe_n_o  = !(state_q == S_DRD || state_q == S_IRD);
  assign ram_we_n_o  = !(state_q == S_DWR && cnt_q != '0 && cnt_q != WR_LAST);
  assign ram_dq_oe_o = (state_q == S_DWR);
  assign ram_dq_o    = (state_q == S_DWR) ? wdata_q : 16'h0000;
  assign inst_data_o = inst_q;
  assign mem_rdata_o = rdata_q;
  assign stall_o     = (state_q != S_DONE) &&
                       (state_q != S_IDLE || inst_en_i || mem_re_i || mem_we_i);

`ifdef UART_MMIO_EN
  assign uart_tx_data_o  = txd_q;
  assign uart_tx_valid_o = (state_q == S_UART) && wreq_q && !maddr_q[0];
  assign uart_rx_ack_o   = (state_q == S_UART) && !wreq_q && rreq_q && !maddr_q[0];
`else
  logic unused_uart;
  assign unused_uart     = ^{uart_tx_ready_i, uart_rx_data_i, uart_rx_valid_i, txd_q};
  assign uart_tx_data_o  = 8'h00;
  assign uart_tx_valid_o = 1'b0;
  assign uart_rx_ack_o   = 1'b0;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Randomised bench for sram_arbiter: a word-level memory model predicts results,
// phase lengths and strobe counts for each transaction.
module tb_sram_arbiter;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] inst_addr_i = '0;
  logic        inst_en_i = 1'b0;
  logic [15:0] inst_data_o;
  logic [15:0] mem_addr_i = '0;
  logic [15:0] mem_wdata_i = '0;
  logic        mem_re_i = 1'b0;
  logic        mem_we_i = 1'b0;
  logic [15:0] mem_rdata_o;
  logic        stall_o;
  logic [17:0] ram_addr_o;
  logic [15:0] ram_dq_i;
  logic [15:0] ram_dq_o;
  logic        ram_dq_oe_o, ram_ce_n_o, ram_oe_n_o, ram_we_n_o;
  logic [7:0]  uart_tx_data_o;
  logic        uart_tx_valid_o;
  logic        uart_tx_ready_i = 1'b0;
  logic [7:0]  uart_rx_data_i = '0;
  logic        uart_rx_valid_i = 1'b0;
  logic        uart_rx_ack_o;

  int checks = 0;
  int errors = 0;

  logic [15:0] sram [0:65535];
  logic [15:0] modelMem [0:65535];
  logic [15:0] expRdata = '0;
  logic [15:0] expInst = '0;

  sram_arbiter #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst),
    .inst_addr_i(inst_addr_i), .inst_en_i(inst_en_i), .inst_data_o(inst_data_o),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_re_i(mem_re_i),
    .mem_we_i(mem_we_i), .mem_rdata_o(mem_rdata_o), .stall_o(stall_o),
    .ram_addr_o(ram_addr_o), .ram_dq_i(ram_dq_i), .ram_dq_o(ram_dq_o),
    .ram_dq_oe_o(ram_dq_oe_o), .ram_ce_n_o(ram_ce_n_o), .ram_oe_n_o(ram_oe_n_o),
    .ram_we_n_o(ram_we_n_o),
    .uart_tx_data_o(uart_tx_data_o), .uart_tx_valid_o(uart_tx_valid_o),
    .uart_tx_ready_i(uart_tx_ready_i), .uart_rx_data_i(uart_rx_data_i),
    .uart_rx_valid_i(uart_rx_valid_i), .uart_rx_ack_o(uart_rx_ack_o)
  );

  always #5 clk = ~clk;

  // Async SRAM stand-in: reads while ce/oe are low, writes while ce/we are low.
  assign ram_dq_i = (!ram_ce_n_o && !ram_oe_n_o) ? sram[ram_addr_o[15:0]] : 16'hDEAD;
  always @(posedge clk)
    if (!ram_ce_n_o && !ram_we_n_o && ram_dq_oe_o) sram[ram_addr_o[15:0]] = ram_dq_o;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    sram[a] = d;
    modelMem[a] = d;
  endtask

  task automatic dropInputs();
    inst_en_i = 1'b0;
    mem_re_i  = 1'b0;
    mem_we_i  = 1'b0;
  endtask

  // One transaction: the model derives every expectation from the request mix alone.
  task automatic applyStimulus(input logic f, input logic [15:0] ia, input logic re,
                               input logic we, input logic [15:0] ma, input logic [15:0] wd);
    int dataLen, expStall, expOe, nStall, nOe, nWe, nPulse, nDqOe, addrErr, dqErr, uartErr, k;
    logic prevWe, done;
    logic [17:0] expAddr;
    dataLen  = we ? W + 2 : (re ? W + 1 : 0);
    expStall = (f || re || we) ? 1 + dataLen + (f ? W + 1 : 0) : 0;
    expOe    = ((!we && re) ? W + 1 : 0) + (f ? W + 1 : 0);
    if (we) modelMem[ma] = wd;
    else if (re) expRdata = modelMem[ma];
    if (f) expInst = modelMem[ia];
    nStall = 0; nOe = 0; nWe = 0; nPulse = 0; nDqOe = 0;
    addrErr = 0; dqErr = 0; uartErr = 0; k = 0;
    prevWe = 1'b1; done = 1'b0;
    @(negedge clk);
    inst_en_i = f; inst_addr_i = ia; mem_re_i = re; mem_we_i = we;
    mem_addr_i = ma; mem_wdata_i = wd;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (uart_tx_valid_o || uart_rx_ack_o) uartErr++;
      if (!stall_o) begin
        done = 1'b1;
        dropInputs();
      end else begin
        nStall++;
        if (!ram_ce_n_o) begin
          expAddr = (k < dataLen) ? {2'b00, ma} : {2'b00, ia};
          if (ram_addr_o !== expAddr) addrErr++;
          k++;
        end
        if (!ram_oe_n_o) nOe++;
        if (!ram_we_n_o) begin
          nWe++;
          if (prevWe) nPulse++;
          if (ram_dq_o !== wd) dqErr++;
        end
        prevWe = ram_we_n_o;
        if (ram_dq_oe_o) nDqOe++;
        @(negedge clk);
        inst_en_i   = 1'($urandom_range(0, 1));
        mem_re_i    = 1'($urandom_range(0, 1));
        mem_we_i    = 1'($urandom_range(0, 1));
        inst_addr_i = 16'($urandom);
        mem_addr_i  = 16'($urandom);
        mem_wdata_i = 16'($urandom);
      end
    end
    if (!done) begin
      dropInputs();
      checkOutput("timeout", 32'(done), 32'd1);
    end
    checkOutput("stall_cycles", 32'(nStall), 32'(expStall));
    checkOutput("ce_low_cycles", 32'(k), 32'(expStall > 0 ? expStall - 1 : 0));
    checkOutput("oe_low_cycles", 32'(nOe), 32'(expOe));
    checkOutput("we_low_cycles", 32'(nWe), 32'(we ? W : 0));
    checkOutput("we_pulses", 32'(nPulse), 32'(we ? 1 : 0));
    checkOutput("dq_oe_cycles", 32'(nDqOe), 32'(we ? W + 2 : 0));
    checkOutput("addr_errors", 32'(addrErr), 32'd0);
    checkOutput("dq_errors", 32'(dqErr), 32'd0);
    checkOutput("uart_idle", 32'(uartErr), 32'd0);
    checkOutput("mem_rdata", 32'(mem_rdata_o), 32'(expRdata));
    checkOutput("inst_data", 32'(inst_data_o), 32'(expInst));
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) preload(16'(i), 16'(i * 7 + 3) ^ 16'h5A5A);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("rst_stall", 32'(stall_o), 32'd0);
    checkOutput("rst_strobes", 32'({ram_ce_n_o, ram_oe_n_o, ram_we_n_o, ram_dq_oe_o}), 32'hE);
    checkOutput("rst_addr", 32'(ram_addr_o), 32'd0);
    checkOutput("rst_data", 32'({inst_data_o, mem_rdata_o}), 32'd0);
    checkOutput("rst_uart", 32'({uart_tx_data_o, uart_tx_valid_o, uart_rx_ack_o}), 32'd0);
    rst = 1'b0;

    // directed cases
    preload(16'h0004, 16'h4E01);
    applyStimulus(1'b1, 16'h0004, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("t1_inst", 32'(inst_data_o), 32'h4E01);
    preload(16'h8000, 16'h1234);
    preload(16'h0005, 16'h6A7F);
    applyStimulus(1'b1, 16'h0005, 1'b1, 1'b0, 16'h8000, 16'h0000);
    checkOutput("t2_rdata", 32'(mem_rdata_o), 32'h1234);
    applyStimulus(1'b1, 16'h0006, 1'b0, 1'b1, 16'h8001, 16'hBEEF);
    checkOutput("t3_sram", 32'(sram[16'h8001]), 32'hBEEF);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1, 16'h8002, 16'hC0DE);
    applyStimulus(1'b1, 16'h8002, 1'b0, 1'b0, 16'h0000, 16'h0000);
    checkOutput("t4_fetch_written", 32'(inst_data_o), 32'hC0DE);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);

    // reset in the middle of a write
    @(negedge clk);
    inst_en_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 16'h8003; mem_wdata_i = 16'h7777;
    @(negedge clk);
    dropInputs();
    @(negedge clk);
    #1;
    checkOutput("t5_we_low", 32'(ram_we_n_o), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("t5_strobes", 32'({ram_ce_n_o, ram_oe_n_o, ram_we_n_o, ram_dq_oe_o}), 32'hE);
    checkOutput("t5_stall", 32'(stall_o), 32'd0);
    checkOutput("t5_outputs", 32'({inst_data_o, mem_rdata_o}), 32'd0);
    checkOutput("t5_addr", 32'(ram_addr_o), 32'd0);
    rst = 1'b0;
    expRdata = '0;
    expInst = '0;

`ifdef UART_MMIO_EN
    uart_tx_ready_i = 1'b1; uart_rx_valid_i = 1'b1; uart_rx_data_i = 8'h5C;
    @(negedge clk);
    mem_re_i = 1'b1; mem_addr_i = 16'hBF01;
    @(negedge clk);
    dropInputs();
    #1;
    checkOutput("t6_uart_stall", 32'(stall_o), 32'd1);
    checkOutput("t6_uart_ce", 32'(ram_ce_n_o), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("t6_status", 32'(mem_rdata_o), 32'h0003);
    checkOutput("t6_done_stall", 32'(stall_o), 32'd0);
    @(negedge clk);
    mem_we_i = 1'b1; mem_addr_i = 16'hBF00; mem_wdata_i = 16'h0041;
    @(negedge clk);
    dropInputs();
    #1;
    checkOutput("t6_tx", 32'({uart_tx_valid_o, uart_tx_data_o}), 32'h141);
    checkOutput("t6_tx_strobes", 32'({ram_ce_n_o, ram_we_n_o, ram_dq_oe_o}), 32'h6);
    @(negedge clk);
    #1;
    checkOutput("t6_tx_pulse", 32'(uart_tx_valid_o), 32'd0);
    @(negedge clk);
    mem_re_i = 1'b1; mem_addr_i = 16'hBF00;
    @(negedge clk);
    dropInputs();
    #1;
    checkOutput("t6_rx_ack", 32'(uart_rx_ack_o), 32'd1);
    @(negedge clk);
    #1;
    checkOutput("t6_rx_data", 32'(mem_rdata_o), 32'h005C);
    checkOutput("t6_rx_ack_pulse", 32'(uart_rx_ack_o), 32'd0);
    expRdata = 16'h005C;
`else
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 16'hBF00, 16'h0041);
    applyStimulus(1'b1, 16'hBF00, 1'b1, 1'b0, 16'hBF00, 16'h0000);
    checkOutput("nommio_sram", 32'(mem_rdata_o), 32'h0041);
`endif

    // randomised traffic on a small address window so stores and fetches collide
    for (int n = 0; n < 40; n++) begin
      applyStimulus(1'($urandom_range(0, 3) != 0), 16'($urandom_range(0, 15)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                    16'($urandom_range(0, 15)), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
